// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, conditional jump/branch, call/return via internal stack.
// Latency: pc_out/depth/ovf/unf register one cycle after the sampling edge; halted is combinational from pc_out.
// Backpressure: en=0 stalls all state; no ready handshake, the decoder sees the stall via its own enable.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   en                  advance enable (0 = hold everything)
//   op, cond            operation select and taken qualifier for JMP/BR
//   target, offset      absolute address (JMP/CALL) and signed displacement (BR)
//   pc_out, depth       current fetch address and number of valid return-stack entries
//   ovf, unf            sticky stack overflow / underflow flags
//   halted              PC parked at LIMIT with wrapping disabled
module pc_sequencer #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] LIMIT     = {WIDTH{1'b1}},
  parameter bit               WRAP      = 1'b1,
  localparam int              DW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             cond,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc_out,
  output logic [DW-1:0]    depth,
  output logic             ovf,
  output logic             unf,
  output logic             halted
);

  // Stack index width; kept at least 1 bit so DEPTH=1 still has a legal index.
  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BR   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] inc_pc;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next_pc;
  logic [DW-1:0]    depth_m1;
  logic [DW-1:0]    next_depth;
  logic             push;
  logic             set_ovf;
  logic             set_unf;

  assign pc_plus1 = pc_out + WIDTH'(1);
  assign depth_m1 = depth - DW'(1);
  // Only consumed when depth > 0, so depth_m1 always addresses a valid entry then.
  assign top      = stack[depth_m1[AW-1:0]];
  assign halted   = !WRAP && (pc_out == LIMIT);

  // Sequential fall-through; at LIMIT either wrap or park (park shows up as halted).
  always_comb begin
    inc_pc = pc_plus1;
    if (pc_out == LIMIT) begin
      inc_pc = WRAP ? RESET_VEC : pc_out;
    end
  end

  always_comb begin
    next_pc    = pc_out;
    next_depth = depth;
    push       = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (en) begin
      next_pc = inc_pc;
      case (op)
        OP_JMP: begin
          if (cond) next_pc = target;
        end
        OP_BR: begin
          // Two's-complement add with carry dropped gives the signed displacement.
          if (cond) next_pc = pc_out + offset;
        end
        OP_CALL: begin
          next_pc = target;
          if (depth == FULL) begin
            set_ovf = 1'b1;
          end else begin
            push       = 1'b1;
            next_depth = depth + DW'(1);
          end
        end
        OP_RET: begin
          if (depth != '0) begin
            next_pc    = top;
            next_depth = depth_m1;
          end else begin
            set_unf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out <= RESET_VEC;
      depth  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      pc_out <= next_pc;
      depth  <= next_depth;
      ovf    <= ovf | set_ovf;
      unf    <= unf | set_unf;
    end
  end

  // Stack contents need no reset; depth alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack[depth[AW-1:0]] <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] op;
  logic       cond;
  logic [7:0] target;
  logic [7:0] offset;

  logic [7:0] pa, pb;
  logic [2:0] da, db;
  logic       ovfa, ovfb, unfa, unfb, hlta, hltb;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  // Instance A: defaults (wrap at 0xFF). Instance B: LIMIT=0x07, no wrap.
  pc_sequencer dut_a (
    .clk(clk), .reset(reset), .en(en), .op(op), .cond(cond),
    .target(target), .offset(offset),
    .pc_out(pa), .depth(da), .ovf(ovfa), .unf(unfa), .halted(hlta)
  );

  pc_sequencer #(.LIMIT(8'h07), .WRAP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .op(op), .cond(cond),
    .target(target), .offset(offset),
    .pc_out(pb), .depth(db), .ovf(ovfb), .unf(unfb), .halted(hltb)
  );

  // Reference model: per-instance PC, array stack with count, sticky flags.
  logic [7:0] m_pc  [2];
  logic [7:0] m_stk [2][4];
  int         m_n   [2];
  bit         m_ovf [2];
  bit         m_unf [2];

  task automatic model_step(input int i);
    logic [7:0] lim;
    bit         wrap;
    logic [7:0] seq;
    lim  = (i == 0) ? 8'hFF : 8'h07;
    wrap = (i == 0);
    if (reset) begin
      m_pc[i] = 8'h00; m_n[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
    end else if (en) begin
      if (m_pc[i] != lim)  seq = m_pc[i] + 8'd1;
      else if (wrap)       seq = 8'h00;
      else                 seq = m_pc[i];
      if (op == 3'd1 && cond)      m_pc[i] = target;
      else if (op == 3'd2 && cond) m_pc[i] = 8'((int'(m_pc[i]) + int'($signed(offset)) + 256) % 256);
      else if (op == 3'd3) begin
        if (m_n[i] == 4) m_ovf[i] = 1;
        else begin m_stk[i][m_n[i]] = m_pc[i] + 8'd1; m_n[i]++; end
        m_pc[i] = target;
      end else if (op == 3'd4) begin
        if (m_n[i] == 0) begin m_unf[i] = 1; m_pc[i] = seq; end
        else begin m_n[i]--; m_pc[i] = m_stk[i][m_n[i]]; end
      end else m_pc[i] = seq;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pc_a",  32'(pa),   32'(m_pc[0]));
      chk("dep_a", 32'(da),   32'(m_n[0]));
      chk("ovf_a", 32'(ovfa), 32'(m_ovf[0]));
      chk("unf_a", 32'(unfa), 32'(m_unf[0]));
      chk("hlt_a", 32'(hlta), 32'(0));
      chk("pc_b",  32'(pb),   32'(m_pc[1]));
      chk("dep_b", 32'(db),   32'(m_n[1]));
      chk("ovf_b", 32'(ovfb), 32'(m_ovf[1]));
      chk("unf_b", 32'(unfb), 32'(m_unf[1]));
      chk("hlt_b", 32'(hltb), 32'(m_pc[1] == 8'h07));
    end
  end

  // Apply one set of inputs across one rising edge; returns at the next falling edge.
  task automatic step(input bit r, input bit e, input logic [2:0] o, input bit c,
                      input logic [7:0] t, input logic [7:0] off);
    reset = r; en = e; op = o; cond = c; target = t; offset = off;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic inc();                   step(0, 1, 3'd0, 0, 8'h00, 8'h00); endtask
  task automatic jmp(input logic [7:0] t); step(0, 1, 3'd1, 1, t, 8'h00);     endtask
  task automatic call(input logic [7:0] t); step(0, 1, 3'd3, 0, t, 8'h00);    endtask
  task automatic ret();                   step(0, 1, 3'd4, 0, 8'h00, 8'h00); endtask
  task automatic rst();                   step(1, 0, 3'd0, 0, 8'h00, 8'h00); chk_on = 1'b1; endtask

  initial begin
    reset = 1'b1; en = 1'b0; op = 3'd0; cond = 1'b0; target = 8'h00; offset = 8'h00;
    @(negedge clk);

    // 1: reset, increment, stall
    rst();
    chk("t1_rst_pc", 32'(pa), 32'h00);
    chk("t1_rst_dep", 32'(da), 32'h0);
    inc(); chk("t1_inc1", 32'(pa), 32'h01);
    inc(); chk("t1_inc2", 32'(pa), 32'h02);
    inc(); chk("t1_inc3", 32'(pa), 32'h03);
    step(0, 0, 3'd1, 1, 8'h99, 8'h00);
    step(0, 0, 3'd3, 1, 8'h99, 8'h00);
    chk("t1_stall", 32'(pa), 32'h03);
    chk("t1_stall_dep", 32'(da), 32'h0);

    // 2: branch taken/untaken, wrap at 0xFF, unknown op behaves as INC
    jmp(8'h10);
    step(0, 1, 3'd2, 1, 8'h00, 8'hFE); chk("t2_br_taken", 32'(pa), 32'h0E);
    jmp(8'h10);
    step(0, 1, 3'd2, 0, 8'h00, 8'hFE); chk("t2_br_not", 32'(pa), 32'h11);
    step(0, 1, 3'd1, 0, 8'h77, 8'h00); chk("t2_jmp_not", 32'(pa), 32'h12);
    jmp(8'hFF);
    inc(); chk("t2_wrap", 32'(pa), 32'h00);
    step(0, 1, 3'd6, 1, 8'h55, 8'h00); chk("t2_op6", 32'(pa), 32'h01);

    // 3: call / return
    jmp(8'h05);
    call(8'h40); chk("t3_call", 32'(pa), 32'h40); chk("t3_dep1", 32'(da), 32'h1);
    inc(); chk("t3_inc", 32'(pa), 32'h41);
    ret(); chk("t3_ret", 32'(pa), 32'h06); chk("t3_dep0", 32'(da), 32'h0);

    // 4: overflow and underflow
    rst();
    call(8'h10); call(8'h20); call(8'h30); call(8'h40); call(8'h50);
    chk("t4_pc", 32'(pa), 32'h50); chk("t4_dep", 32'(da), 32'h4); chk("t4_ovf", 32'(ovfa), 32'h1);
    ret(); chk("t4_r1", 32'(pa), 32'h31);
    ret(); chk("t4_r2", 32'(pa), 32'h21);
    ret(); chk("t4_r3", 32'(pa), 32'h11);
    ret(); chk("t4_r4", 32'(pa), 32'h01);
    chk("t4_unf_pre", 32'(unfa), 32'h0);
    ret(); chk("t4_r5", 32'(pa), 32'h02); chk("t4_unf", 32'(unfa), 32'h1);

    // 5: halt at LIMIT on instance B
    rst();
    for (int k = 0; k < 7; k++) inc();
    chk("t5_lim", 32'(pb), 32'h07); chk("t5_hlt", 32'(hltb), 32'h1);
    for (int k = 0; k < 3; k++) inc();
    chk("t5_hold", 32'(pb), 32'h07); chk("t5_hlt2", 32'(hltb), 32'h1);
    jmp(8'h02); chk("t5_jmp", 32'(pb), 32'h02); chk("t5_unhlt", 32'(hltb), 32'h0);

    // 6: reset beats a stall and a CALL on the same edge
    rst();
    call(8'h10); call(8'h20); call(8'h30); call(8'h40); call(8'h50);
    ret(); ret(); jmp(8'h33);
    chk("t6_pre_pc", 32'(pa), 32'h33); chk("t6_pre_dep", 32'(da), 32'h2);
    step(1, 0, 3'd3, 1, 8'h44, 8'h00);
    chk("t6_pc", 32'(pa), 32'h00); chk("t6_dep", 32'(da), 32'h0);
    chk("t6_ovf", 32'(ovfa), 32'h0); chk("t6_unf", 32'(unfa), 32'h0);
    call(8'h60); ret(); chk("t6_after", 32'(pa), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
